// File: rtl/mult_pkg.sv
// Shared types and defaults for the sequential shift-and-add multiplier.
package mult_pkg;

    localparam int N_DEFAULT = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ADD   = 2'd1,
        SHIFT = 2'd2
    } mult_state_t;

endpackage

// File: rtl/adder.sv
// n-bit unsigned adder used for the A+M step; carry-out is returned separately.
module adder #(
    parameter int n = 4
) (
    input  logic [n-1:0] A,
    input  logic [n-1:0] M,
    output logic         C,
    output logic [n-1:0] Sum
);

    assign {C, Sum} = {1'b0, A} + {1'b0, M};

endmodule

// File: rtl/seq_multiplier.sv
// Unsigned shift-and-add multiplier: n x n -> 2n, one ADD/SHIFT pair per multiplier bit.
//
// state | meaning
// IDLE  | ready=1, AQ holds last product, waiting for a start rising edge
// ADD   | conditionally add M into A (Q[0]=1), carry captured in C
// SHIFT | shift {C,A,Q} right by one, decrement bit counter
module seq_multiplier
    import mult_pkg::*;
#(
    parameter int n = N_DEFAULT
) (
    input  logic             clock,
    input  logic             n_reset,
    input  logic             start,
    input  logic [n-1:0]     M_in,
    input  logic [n-1:0]     Q_in,
    output logic             ready,
    output logic [2*n-1:0]   AQ
);

    localparam int CW = $clog2(n + 1);

    mult_state_t   state;
    logic          start_d;
    logic [n-1:0]  M;
    logic [n-1:0]  A;
    logic [n-1:0]  Q;
    logic          C;
    logic [CW-1:0] count;
    logic          add_c;
    logic [n-1:0]  add_sum;
    logic          trigger;

    assign trigger = start & ~start_d;
    assign AQ      = {A, Q};

    adder #(.n(n)) u_adder (
        .A   (A),
        .M   (M),
        .C   (add_c),
        .Sum (add_sum)
    );

    // start_d resets high so a start level held through reset is not seen as an edge
    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            state   <= IDLE;
            ready   <= 1'b1;
            start_d <= 1'b1;
            M       <= '0;
            A       <= '0;
            Q       <= '0;
            C       <= 1'b0;
            count   <= '0;
        end else begin
            start_d <= start;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        M     <= M_in;
                        Q     <= Q_in;
                        A     <= '0;
                        C     <= 1'b0;
                        count <= CW'(n);
                        ready <= 1'b0;
                        state <= ADD;
                    end
                end
                ADD: begin
                    if (Q[0]) begin
                        {C, A} <= {add_c, add_sum};
                    end else begin
                        C <= 1'b0;
                    end
                    state <= SHIFT;
                end
                SHIFT: begin
                    // carry from the add step lands in A's MSB here
                    {C, A, Q} <= {1'b0, C, A, Q[n-1:1]};
                    count     <= count - 1'b1;
                    if (count == CW'(1)) begin
                        ready <= 1'b1;
                        state <= IDLE;
                    end else begin
                        state <= ADD;
                    end
                end
                default: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and swept checks of seq_multiplier at n=4 and n=8.
module tb_seq_multiplier;

    logic        clk;
    logic        n_reset;
    logic        start4, start8;
    logic [3:0]  m4, q4;
    logic [7:0]  m8, q8;
    logic        ready4, ready8;
    logic [7:0]  aq4;
    logic [15:0] aq8;

    int total = 0;
    int bad   = 0;

    seq_multiplier #(.n(4)) dut4 (
        .clock(clk), .n_reset(n_reset), .start(start4),
        .M_in(m4), .Q_in(q4), .ready(ready4), .AQ(aq4)
    );

    seq_multiplier #(.n(8)) dut8 (
        .clock(clk), .n_reset(n_reset), .start(start8),
        .M_in(m8), .Q_in(q8), .ready(ready8), .AQ(aq8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] m;
        logic [3:0] q;
        logic [7:0] prod;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Launch one operation, count cycles with ready low, compare product and latency.
    task automatic run_op(input bit wide, input logic [7:0] m, input logic [7:0] q,
                          input logic [15:0] want, input string name);
        int   low;
        logic rd;
        logic [15:0] got;
        @(negedge clk);
        if (wide) begin
            m8 = m; q8 = q; start8 = 1'b1;
        end else begin
            m4 = m[3:0]; q4 = q[3:0]; start4 = 1'b1;
        end
        low = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            rd = wide ? ready8 : ready4;
            if (rd) break;
            low++;
        end
        got = wide ? aq8 : {8'h00, aq4};
        check({name, "_prod"}, 32'(got), 32'(want));
        check({name, "_lat"}, 32'(low), wide ? 32'd16 : 32'd8);
        start4 = 1'b0;
        start8 = 1'b0;
        @(negedge clk);
    endtask

    vec_t vecs[9];

    initial begin
        int   low, falls;
        logic prev;
        logic [7:0] mask;
        logic [3:0] mm, qq;

        vecs[0] = '{4'hE, 4'h6, 8'h54};
        vecs[1] = '{4'hF, 4'hF, 8'hE1};
        vecs[2] = '{4'h0, 4'hB, 8'h00};
        vecs[3] = '{4'h1, 4'h1, 8'h01};
        vecs[4] = '{4'h9, 4'h7, 8'h3F};
        vecs[5] = '{4'hA, 4'h5, 8'h32};
        vecs[6] = '{4'h8, 4'h8, 8'h40};
        vecs[7] = '{4'h3, 4'hD, 8'h27};
        vecs[8] = '{4'h7, 4'h0, 8'h00};

        n_reset = 1'b0;
        start4  = 1'b1;
        start8  = 1'b0;
        m4 = 4'h5; q4 = 4'h5; m8 = '0; q8 = '0;
        repeat (3) @(negedge clk);
        check("reset_ready", 32'(ready4), 32'd1);
        check("reset_aq", 32'(aq4), 32'd0);
        check("reset_aq8", 32'(aq8), 32'd0);
        n_reset = 1'b1;
        repeat (3) @(negedge clk);
        check("held_start_no_trigger", 32'(ready4), 32'd1);
        check("held_start_aq", 32'(aq4), 32'd0);
        start4 = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 9; i++)
            run_op(1'b0, {4'h0, vecs[i].m}, {4'h0, vecs[i].q}, {8'h00, vecs[i].prod},
                   $sformatf("vec%0d", i));

        // start held high, extra edge mid-operation, operands changed after trigger
        @(negedge clk);
        m4 = 4'hD; q4 = 4'hB; start4 = 1'b1;
        low = 0; falls = 0; prev = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!ready4) low++;
            if (prev && !ready4) falls++;
            prev = ready4;
            if (i == 1) begin m4 = 4'h0; q4 = 4'h0; end
            if (i == 2) start4 = 1'b0;
            if (i == 3) start4 = 1'b1;
        end
        check("hold_low_cycles", 32'(low), 32'd8);
        check("hold_ops", 32'(falls), 32'd1);
        check("hold_prod", 32'(aq4), 32'h8F);
        start4 = 1'b0;
        @(negedge clk);

        // asynchronous reset mid-operation
        @(negedge clk);
        m4 = 4'h9; q4 = 4'h7; start4 = 1'b1;
        repeat (4) @(negedge clk);
        check("pre_reset_busy", 32'(ready4), 32'd0);
        #2 n_reset = 1'b0;
        #1;
        check("async_rst_ready", 32'(ready4), 32'd1);
        check("async_rst_aq", 32'(aq4), 32'd0);
        @(negedge clk);
        start4 = 1'b0;
        n_reset = 1'b1;
        @(negedge clk);
        run_op(1'b0, 8'h09, 8'h07, 16'h003F, "after_reset");

        // sweep of all operand pairs in scrambled order
        mask = 8'($urandom_range(0, 255));
        for (int i = 0; i < 256; i++) begin
            {mm, qq} = 8'(i) ^ mask;
            run_op(1'b0, {4'h0, mm}, {4'h0, qq}, 16'(mm) * 16'(qq), $sformatf("sweep_%h_%h", mm, qq));
        end

        run_op(1'b1, 8'hFF, 8'hFF, 16'hFE01, "n8_ff_ff");
        run_op(1'b1, 8'hC3, 8'h5A, 16'h448E, "n8_c3_5a");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
